// File: rtl/rvx_gpio_input_conditioner.sv
// GPIO pad input conditioner: 2-FF synchronizer, per-pin debounce filter,
// edge capture into W1C pending bits with a level interrupt, and a 5-bit register bus.
module rvx_gpio_input_conditioner #(
    parameter int unsigned GPIO_WIDTH = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [4:0]            rw_address,
    output logic [31:0]           read_data,
    input  logic                  read_request,
    output logic                  read_response,
    input  logic [31:0]           write_data,
    input  logic [3:0]            write_strobe,
    input  logic                  write_request,
    output logic                  write_response,
    input  logic [GPIO_WIDTH-1:0] gpio_pad_input,
    output logic [GPIO_WIDTH-1:0] gpio_input,
    output logic                  irq
);

    localparam logic [4:0] AddrDebounce = 5'h00;
    localparam logic [4:0] AddrRiseEn   = 5'h04;
    localparam logic [4:0] AddrFallEn   = 5'h08;
    localparam logic [4:0] AddrPending  = 5'h0C;
    localparam logic [4:0] AddrState    = 5'h10;

    logic [GPIO_WIDTH-1:0] sync1_q, sync2_q;
    logic [GPIO_WIDTH-1:0] gpio_input_q, gpio_input_d;
    logic [15:0]           cnt_q [GPIO_WIDTH];
    logic [15:0]           cnt_d [GPIO_WIDTH];
    logic [GPIO_WIDTH-1:0] update;

    logic [15:0]           debounce_q, debounce_d;
    logic [GPIO_WIDTH-1:0] rise_en_q, rise_en_d;
    logic [GPIO_WIDTH-1:0] fall_en_q, fall_en_d;
    logic [GPIO_WIDTH-1:0] pending_q, pending_d;
    logic [GPIO_WIDTH-1:0] pending_set, pending_clr;

    logic [31:0]           read_data_q, read_data_d;
    logic [31:0]           read_mux;
    logic                  read_response_q, write_response_q;
    logic                  write_ok;
    logic                  unused_write_data;

    // Only full-word, half-word-low and byte-low writes land; others are acknowledged only.
    assign write_ok = write_request &&
                      (write_strobe == 4'b1111 || write_strobe == 4'b0011 ||
                       write_strobe == 4'b0001);

    assign unused_write_data = ^write_data;

    always_comb begin
        debounce_d  = debounce_q;
        rise_en_d   = rise_en_q;
        fall_en_d   = fall_en_q;
        pending_clr = '0;
        if (write_ok) begin
            case (rw_address)
                AddrDebounce: debounce_d  = write_data[15:0];
                AddrRiseEn:   rise_en_d   = write_data[GPIO_WIDTH-1:0];
                AddrFallEn:   fall_en_d   = write_data[GPIO_WIDTH-1:0];
                AddrPending:  pending_clr = write_data[GPIO_WIDTH-1:0];
                default:      ;
            endcase
        end
    end

    // The counter compares against the live DEBOUNCE value, so lowering N can
    // release a pin that has already counted past the new threshold.
    always_comb begin
        gpio_input_d = gpio_input_q;
        update       = '0;
        for (int i = 0; i < int'(GPIO_WIDTH); i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == gpio_input_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= debounce_q) begin
                gpio_input_d[i] = sync2_q[i];
                cnt_d[i]        = '0;
                update[i]       = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    // A set on the same edge as a W1C clear wins.
    always_comb begin
        pending_set = update & ((gpio_input_d & rise_en_q) | (~gpio_input_d & fall_en_q));
        pending_d   = (pending_q & ~pending_clr) | pending_set;
    end

    always_comb begin
        read_mux = '0;
        case (rw_address)
            AddrDebounce: read_mux[15:0]           = debounce_q;
            AddrRiseEn:   read_mux[GPIO_WIDTH-1:0] = rise_en_q;
            AddrFallEn:   read_mux[GPIO_WIDTH-1:0] = fall_en_q;
            AddrPending:  read_mux[GPIO_WIDTH-1:0] = pending_q;
            AddrState:    read_mux[GPIO_WIDTH-1:0] = gpio_input_q;
            default:      read_mux                 = '0;
        endcase
        read_data_d = read_request ? read_mux : read_data_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync1_q          <= '0;
            sync2_q          <= '0;
            gpio_input_q     <= '0;
            debounce_q       <= '0;
            rise_en_q        <= '0;
            fall_en_q        <= '0;
            pending_q        <= '0;
            read_data_q      <= '0;
            read_response_q  <= 1'b0;
            write_response_q <= 1'b0;
            for (int i = 0; i < int'(GPIO_WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q          <= gpio_pad_input;
            sync2_q          <= sync1_q;
            gpio_input_q     <= gpio_input_d;
            debounce_q       <= debounce_d;
            rise_en_q        <= rise_en_d;
            fall_en_q        <= fall_en_d;
            pending_q        <= pending_d;
            read_data_q      <= read_data_d;
            read_response_q  <= read_request;
            write_response_q <= write_request;
            for (int i = 0; i < int'(GPIO_WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign gpio_input     = gpio_input_q;
    assign irq            = |pending_q;
    assign read_data      = read_data_q;
    assign read_response  = read_response_q;
    assign write_response = write_response_q;

endmodule

// File: tb/tb_rvx_gpio_input_conditioner.sv
// Directed bench for rvx_gpio_input_conditioner: a register-access vector table
// followed by hand-timed sequences for latency, debounce, edge capture and reset.
module tb_rvx_gpio_input_conditioner;

    localparam int unsigned W = 8;

    logic         clock;
    logic         reset_n;
    logic [4:0]   rw_address;
    logic [31:0]  read_data;
    logic         read_request;
    logic         read_response;
    logic [31:0]  write_data;
    logic [3:0]   write_strobe;
    logic         write_request;
    logic         write_response;
    logic [W-1:0] gpio_pad_input;
    logic [W-1:0] gpio_input;
    logic         irq;

    int n_checks = 0;
    int n_errors = 0;

    rvx_gpio_input_conditioner #(.GPIO_WIDTH(W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .rw_address     (rw_address),
        .read_data      (read_data),
        .read_request   (read_request),
        .read_response  (read_response),
        .write_data     (write_data),
        .write_strobe   (write_strobe),
        .write_request  (write_request),
        .write_response (write_response),
        .gpio_pad_input (gpio_pad_input),
        .gpio_input     (gpio_input),
        .irq            (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input bit wr, input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [31:0] exp, input string name);
        vec_t v;
        v.wr   = wr;
        v.addr = addr;
        v.data = data;
        v.strb = strb;
        v.exp  = exp;
        v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        rw_address    = a;
        write_data    = d;
        write_strobe  = s;
        write_request = 1'b1;
        step(1);
        write_request = 1'b0;
        check("write_response", {31'd0, write_response}, 32'd1);
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        rw_address   = a;
        read_request = 1'b1;
        step(1);
        read_request = 1'b0;
        d = read_data;
        check("read_response", {31'd0, read_response}, 32'd1);
    endtask

    task automatic read_expect(input logic [4:0] a, input logic [31:0] exp, input string name);
        logic [31:0] rd;
        bus_read(a, rd);
        check(name, rd, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n        = 1'b0;
        rw_address     = '0;
        read_request   = 1'b0;
        write_data     = '0;
        write_strobe   = '0;
        write_request  = 1'b0;
        gpio_pad_input = '0;

        add_vec(0, 5'h00, 32'h0, 4'hF, 32'h0000_0000, "rst_debounce");
        add_vec(0, 5'h04, 32'h0, 4'hF, 32'h0000_0000, "rst_rise_en");
        add_vec(0, 5'h08, 32'h0, 4'hF, 32'h0000_0000, "rst_fall_en");
        add_vec(0, 5'h0C, 32'h0, 4'hF, 32'h0000_0000, "rst_pending");
        add_vec(0, 5'h10, 32'h0, 4'hF, 32'h0000_0000, "rst_state");
        add_vec(0, 5'h14, 32'h0, 4'hF, 32'h0000_0000, "rst_unmapped");
        add_vec(1, 5'h00, 32'hFFFF_1234, 4'hF, 32'h0, "wr_debounce");
        add_vec(0, 5'h00, 32'h0, 4'hF, 32'h0000_1234, "rd_debounce_16b");
        add_vec(1, 5'h04, 32'hFFFF_FFA5, 4'h3, 32'h0, "wr_rise_en_s3");
        add_vec(0, 5'h04, 32'h0, 4'hF, 32'h0000_00A5, "rd_rise_en");
        add_vec(1, 5'h04, 32'h0000_0011, 4'h4, 32'h0, "wr_rise_en_s4");
        add_vec(0, 5'h04, 32'h0, 4'hF, 32'h0000_00A5, "rd_rise_en_kept");
        add_vec(1, 5'h08, 32'h0000_003C, 4'h1, 32'h0, "wr_fall_en_s1");
        add_vec(0, 5'h08, 32'h0, 4'hF, 32'h0000_003C, "rd_fall_en");
        add_vec(1, 5'h08, 32'h0000_0000, 4'h8, 32'h0, "wr_fall_en_s8");
        add_vec(0, 5'h08, 32'h0, 4'hF, 32'h0000_003C, "rd_fall_en_kept");
        add_vec(1, 5'h14, 32'hFFFF_FFFF, 4'hF, 32'h0, "wr_unmapped");
        add_vec(0, 5'h14, 32'h0, 4'hF, 32'h0000_0000, "rd_unmapped");
        add_vec(1, 5'h10, 32'hFFFF_FFFF, 4'hF, 32'h0, "wr_state_ro");
        add_vec(0, 5'h10, 32'h0, 4'hF, 32'h0000_0000, "rd_state_ro");
        add_vec(1, 5'h00, 32'h0, 4'hF, 32'h0, "clr_debounce");
        add_vec(1, 5'h04, 32'h0, 4'hF, 32'h0, "clr_rise_en");
        add_vec(1, 5'h08, 32'h0, 4'hF, 32'h0, "clr_fall_en");
        add_vec(0, 5'h00, 32'h0, 4'hF, 32'h0000_0000, "rd_debounce_zero");

        step(3);
        check("rst_gpio_input", {24'd0, gpio_input}, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        check("rst_read_response", {31'd0, read_response}, 32'h0);
        check("rst_write_response", {31'd0, write_response}, 32'h0);
        check("rst_read_data", read_data, 32'h0);
        reset_n = 1'b1;
        step(1);

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
                step(1);
            end else begin
                read_expect(vecs[i].addr, vecs[i].exp, vecs[i].name);
                step(1);
                check({vecs[i].name, "_hold"}, read_data, vecs[i].exp);
            end
            check("read_response_idle", {31'd0, read_response}, 32'h0);
            check("write_response_idle", {31'd0, write_response}, 32'h0);
        end
        check("table_irq", {31'd0, irq}, 32'h0);

        // N=0 rising edge: visible at k+2
        bus_write(5'h04, 32'h1, 4'hF);
        gpio_pad_input[0] = 1'b1;
        step(1);
        check("n0_k0", {24'd0, gpio_input}, 32'h00);
        step(1);
        check("n0_k1", {24'd0, gpio_input}, 32'h00);
        step(1);
        check("n0_k2", {24'd0, gpio_input}, 32'h01);
        check("n0_k2_irq", {31'd0, irq}, 32'h1);
        read_expect(5'h0C, 32'h1, "n0_pending");
        read_expect(5'h10, 32'h1, "n0_state");
        bus_write(5'h0C, 32'h1, 4'hF);
        check("n0_w1c_irq", {31'd0, irq}, 32'h0);

        // N=4: short pulses are filtered, steady level passes at k+6
        bus_write(5'h00, 32'd4, 4'hF);
        gpio_pad_input[0] = 1'b0;
        step(3);
        gpio_pad_input[0] = 1'b1;
        step(10);
        check("n4_low_glitch", {24'd0, gpio_input}, 32'h01);
        gpio_pad_input[0] = 1'b0;
        step(12);
        check("n4_fall", {24'd0, gpio_input}, 32'h00);
        read_expect(5'h0C, 32'h0, "n4_fall_no_pending");
        gpio_pad_input[0] = 1'b1;
        step(3);
        gpio_pad_input[0] = 1'b0;
        step(10);
        check("n4_high_glitch", {24'd0, gpio_input}, 32'h00);
        check("n4_glitch_irq", {31'd0, irq}, 32'h0);
        gpio_pad_input[0] = 1'b1;
        step(6);
        check("n4_k5", {24'd0, gpio_input}, 32'h00);
        step(1);
        check("n4_k6", {24'd0, gpio_input}, 32'h01);
        check("n4_k6_irq", {31'd0, irq}, 32'h1);
        bus_write(5'h0C, 32'h1, 4'hF);
        check("n4_w1c_irq", {31'd0, irq}, 32'h0);

        // Multi-pin: only enabled falling edges latch
        bus_write(5'h00, 32'd0, 4'hF);
        bus_write(5'h04, 32'd0, 4'hF);
        gpio_pad_input = 8'h81;
        step(4);
        check("mp_rise", {24'd0, gpio_input}, 32'h81);
        read_expect(5'h0C, 32'h0, "mp_rise_no_pending");
        bus_write(5'h08, 32'h0F, 4'hF);
        gpio_pad_input = 8'h00;
        step(4);
        check("mp_fall", {24'd0, gpio_input}, 32'h00);
        check("mp_fall_irq", {31'd0, irq}, 32'h1);
        read_expect(5'h0C, 32'h01, "mp_fall_pending");
        gpio_pad_input = 8'h81;
        step(4);
        check("mp_rise2", {24'd0, gpio_input}, 32'h81);
        read_expect(5'h0C, 32'h01, "mp_rise2_pending");
        bus_write(5'h0C, 32'hFF, 4'hF);
        check("mp_w1c_irq", {31'd0, irq}, 32'h0);

        // Set and W1C clear of pin 1 on the same edge: set wins
        bus_write(5'h08, 32'h0, 4'hF);
        bus_write(5'h04, 32'h02, 4'hF);
        gpio_pad_input[1] = 1'b1;
        step(2);
        bus_write(5'h0C, 32'h02, 4'hF);
        check("collide_gpio", {24'd0, gpio_input}, 32'h83);
        check("collide_irq", {31'd0, irq}, 32'h1);
        bus_write(5'h04, 32'h0, 4'hF);
        read_expect(5'h0C, 32'h02, "pending_after_en_clear");
        bus_write(5'h0C, 32'h02, 4'hF);
        check("collide_w1c_irq", {31'd0, irq}, 32'h0);

        // Reset mid-count with N=100
        bus_write(5'h00, 32'd100, 4'hF);
        bus_write(5'h04, 32'hFF, 4'hF);
        gpio_pad_input = 8'h00;
        step(20);
        check("midcount_gpio", {24'd0, gpio_input}, 32'h83);
        reset_n = 1'b0;
        step(2);
        check("mreset_gpio", {24'd0, gpio_input}, 32'h00);
        check("mreset_irq", {31'd0, irq}, 32'h0);
        check("mreset_read_data", read_data, 32'h0);
        reset_n = 1'b1;
        read_expect(5'h00, 32'h0, "mreset_debounce");
        read_expect(5'h0C, 32'h0, "mreset_pending");
        read_expect(5'h10, 32'h0, "mreset_state");
        read_expect(5'h04, 32'h0, "mreset_rise_en");

        // Pad high after reset rises with normal latency
        bus_write(5'h04, 32'h1, 4'hF);
        gpio_pad_input = 8'h01;
        step(2);
        check("post_rst_k1", {24'd0, gpio_input}, 32'h00);
        step(1);
        check("post_rst_k2", {24'd0, gpio_input}, 32'h01);
        check("post_rst_irq", {31'd0, irq}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
